mem_port_arbiter: RTL and testbench

- Multi-channel, byte-serial memory controller between the core's memory clients (instruction fetch, load/store buffer, and further clients) and the single 8-bit RAM/IO port.
- Arbitrates NCH request channels round-robin and serialises 1..DATA_BYTES-byte reads and writes.
- Sign- or zero-extends load data.
- Aborts reads whose requester withdraws mid-transfer.
- Stalls IO writes while the UART buffer is full.

---
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: client channel bundle plus byte-wide RAM/IO port (master=clients/RAM, slave=arbiter)
interface mem_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = 4
);
  logic rdy;
  logic [NCH-1:0] req, we, sext, ack;
  logic [3*NCH-1:0] len;
  logic [ADDR_W*NCH-1:0] addr;
  logic [8*DATA_BYTES*NCH-1:0] wdata;
  logic [8*DATA_BYTES-1:0] rdata;
  logic [7:0] mem_din, mem_dout;
  logic io_full, mem_wr;
  logic [ADDR_W-1:0] mem_a;
  modport master (
    output rdy, req, we, sext, len, addr, wdata, mem_din, io_full,
    input rdata, ack, mem_wr, mem_a, mem_dout
  );
  modport slave (
    input rdy, req, we, sext, len, addr, wdata, mem_din, io_full,
    output rdata, ack, mem_wr, mem_a, mem_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin NCH-channel byte-serial RAM/IO controller (clk, rst, bus.slave: req/we/sext/len/addr/wdata -> rdata/ack; mem_a/mem_wr/mem_dout/mem_din; io_full stall; rdy freeze)
module mem_port_arbiter #(
  parameter int NCH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [2:0] DB = 3'(DATA_BYTES);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t st;
  logic [PW-1:0] ptr, g, gnt, nxt;
  logic found, sext_q, g_stall, w_stall;
  logic [2:0] k, len_q, g_len_raw, g_len;
  logic [ADDR_W-1:0] a_q, g_addr, cur;
  logic [DW-1:0] wd_q, g_wdata, cap, ext;
  logic [NCH-1:0] g_hot;
  always_comb begin
    found = 1'b0;
    gnt = ptr;
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.req[(int'(ptr) + i) % NCH]) begin
        found = 1'b1;
        gnt = PW'((int'(ptr) + i) % NCH);
      end
  end
  assign nxt = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
  assign g_len_raw = bus.len[3*gnt +: 3];
  assign g_len = (g_len_raw == 3'd0 || g_len_raw > DB) ? DB : g_len_raw;
  assign g_addr = bus.addr[ADDR_W*gnt +: ADDR_W];
  assign g_wdata = bus.wdata[DW*gnt +: DW];
  assign g_stall = g_addr >= IO_BASE && bus.io_full;
  assign cur = a_q + ADDR_W'(k);
  assign w_stall = cur >= IO_BASE && bus.io_full;
  assign g_hot = NCH'(1) << g;
  // bytes above k take the sign of the byte just captured; on the last capture that is byte len-1
  always_comb begin
    cap = bus.rdata;
    cap[8*k +: 8] = bus.mem_din;
    ext = cap;
    for (int b = 0; b < DATA_BYTES; b++)
      if (b > int'(k)) ext[8*b +: 8] = {8{sext_q & bus.mem_din[7]}};
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      g <= '0;
      k <= '0;
      sext_q <= 1'b0;
      len_q <= '0;
      a_q <= '0;
      wd_q <= '0;
      bus.mem_wr <= 1'b0;
      bus.mem_a <= '0;
      bus.mem_dout <= '0;
      bus.ack <= '0;
      bus.rdata <= '0;
    end else if (bus.rdy)
      case (st)
        IDLE: if (found) begin
          g <= gnt;
          ptr <= nxt;
          sext_q <= bus.sext[gnt];
          len_q <= g_len;
          a_q <= g_addr;
          wd_q <= g_wdata;
          bus.mem_a <= g_addr;
          bus.mem_dout <= g_wdata[7:0];
          bus.mem_wr <= bus.we[gnt] && !g_stall;
          k <= {2'b00, bus.we[gnt] && !g_stall};
          st <= bus.we[gnt] ? WRITE : READ;
        end
        READ: if (!bus.req[g]) st <= IDLE;
        else begin
          bus.rdata <= ext;
          k <= k + 3'd1;
          bus.mem_a <= bus.mem_a + 1'b1;
          if (k == len_q - 3'd1) begin
            bus.ack <= g_hot;
            st <= DONE;
          end
        end
        WRITE: if (k == len_q) begin
          bus.mem_wr <= 1'b0;
          bus.ack <= g_hot;
          st <= DONE;
        end else begin
          bus.mem_wr <= !w_stall;
          bus.mem_a <= cur;
          bus.mem_dout <= wd_q[8*k +: 8];
          k <= w_stall ? k : k + 3'd1;
        end
        default: begin
          bus.ack <= '0;
          st <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int NCH = 2, ADDR_W = 32, DB = 4;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0, cyc, n;
  logic [1:0] ak;
  logic [7:0] ram [0:1023];
  mem_port_arbiter_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_BYTES(DB)) bus();
  mem_port_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_BYTES(DB), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  assign bus.mem_din = ram[bus.mem_a[9:0]];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic setch(input int ch, input logic w, input logic sx, input logic [2:0] ln,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.we[ch] = w;
    bus.sext[ch] = sx;
    bus.len[3*ch +: 3] = ln;
    bus.addr[32*ch +: 32] = a;
    bus.wdata[32*ch +: 32] = wd;
    bus.req[ch] = 1'b1;
  endtask
  task automatic xfer(input int ch, input logic w, input logic sx, input logic [2:0] ln,
                      input logic [31:0] a, input logic [31:0] wd, output int c, output logic [1:0] av);
    setch(ch, w, sx, ln, a, wd);
    c = -1;
    av = '0;
    for (int i = 1; i <= 20 && c < 0; i++) begin
      tick;
      if (bus.ack != 0) begin
        c = i;
        av = bus.ack;
      end
    end
    bus.req[ch] = 1'b0;
    tick;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h200] = 8'h80; ram[10'h210] = 8'h01; ram[10'h211] = 8'h80;
    bus.rdy = 1'b1; bus.req = '0; bus.we = '0; bus.sext = '0; bus.len = '0;
    bus.addr = '0; bus.wdata = '0; bus.io_full = 1'b0;
    tick; tick;
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_a", bus.mem_a, 0);
    chk("rst_dout", bus.mem_dout, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    setch(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0);
    tick;
    chk("rd_a0", bus.mem_a, 32'h100);
    chk("rd_wr", bus.mem_wr, 0);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk($sformatf("rd_a%0d", i), bus.mem_a, 32'h100 + i);
      chk("rd_ack_early", bus.ack, 0);
    end
    tick;
    chk("rd_ack", bus.ack, 2'b10);
    chk("rd_data", bus.rdata, 32'h44332211);
    bus.req[1] = 1'b0;
    tick;
    chk("rd_ack_off", bus.ack, 0);
    xfer(0, 1'b0, 1'b1, 3'd1, 32'h200, 32'h0, cyc, ak);
    chk("sx1_cyc", cyc, 2); chk("sx1_ack", ak, 2'b01); chk("sx1_data", bus.rdata, 32'hFFFFFF80);
    xfer(1, 1'b0, 1'b0, 3'd1, 32'h200, 32'h0, cyc, ak);
    chk("zx1_cyc", cyc, 2); chk("zx1_ack", ak, 2'b10); chk("zx1_data", bus.rdata, 32'h00000080);
    xfer(0, 1'b0, 1'b1, 3'd0, 32'h100, 32'h0, cyc, ak);
    chk("len0_cyc", cyc, 5); chk("len0_ack", ak, 2'b01); chk("len0_data", bus.rdata, 32'h44332211);
    setch(0, 1'b0, 1'b1, 3'd2, 32'h210, 32'h0);
    tick;
    chk("hw_a0", bus.mem_a, 32'h210);
    bus.rdy = 1'b0;
    tick; tick;
    chk("frz_a", bus.mem_a, 32'h210);
    chk("frz_ack", bus.ack, 0);
    bus.rdy = 1'b1;
    tick;
    chk("hw_a1", bus.mem_a, 32'h211);
    tick;
    chk("hw_ack", bus.ack, 2'b01);
    chk("hw_data", bus.rdata, 32'hFFFF8001);
    bus.req[0] = 1'b0;
    tick;
    bus.io_full = 1'b1;
    setch(0, 1'b1, 1'b0, 3'd2, 32'h40, 32'hBEEF);
    tick;
    chk("wr0_wr", bus.mem_wr, 1); chk("wr0_a", bus.mem_a, 32'h40); chk("wr0_d", bus.mem_dout, 8'hEF);
    tick;
    chk("wr1_wr", bus.mem_wr, 1); chk("wr1_a", bus.mem_a, 32'h41); chk("wr1_d", bus.mem_dout, 8'hBE);
    chk("wr1_ack", bus.ack, 0);
    tick;
    chk("wr_end_wr", bus.mem_wr, 0); chk("wr_ack", bus.ack, 2'b01);
    bus.req[0] = 1'b0;
    bus.io_full = 1'b0;
    tick;
    chk("wr_idle_wr", bus.mem_wr, 0); chk("wr_idle_ack", bus.ack, 0);
    setch(0, 1'b0, 1'b0, 3'd1, 32'h100, 32'h0);
    setch(1, 1'b0, 1'b0, 3'd1, 32'h200, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("rr_first", bus.mem_a, 32'h100);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      tick;
      if (bus.ack != 0) begin
        chk($sformatf("rr_ack%0d", n), bus.ack, (n % 2) ? 2'b10 : 2'b01);
        chk($sformatf("rr_data%0d", n), bus.rdata, (n % 2) ? 32'h80 : 32'h11);
        n++;
      end
    end
    chk("rr_count", n, 4);
    bus.req = '0;
    tick; tick;
    setch(0, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0);
    tick; tick; tick;
    chk("ab_a", bus.mem_a, 32'h102);
    bus.req[0] = 1'b0;
    setch(1, 1'b0, 1'b0, 3'd1, 32'h200, 32'h0);
    tick;
    chk("ab_noack", bus.ack, 0); chk("ab_wr", bus.mem_wr, 0);
    tick;
    chk("ab_regrant", bus.mem_a, 32'h200); chk("ab_ack0", bus.ack, 0);
    tick;
    chk("ab_ack", bus.ack, 2'b10); chk("ab_data", bus.rdata, 32'h80);
    bus.req[1] = 1'b0;
    tick;
    bus.io_full = 1'b1;
    setch(0, 1'b1, 1'b0, 3'd1, 32'h30000, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("st_wr%0d", i), bus.mem_wr, 0);
      chk("st_ack", bus.ack, 0);
    end
    bus.io_full = 1'b0;
    tick;
    chk("st_go_wr", bus.mem_wr, 1); chk("st_go_a", bus.mem_a, 32'h30000); chk("st_go_d", bus.mem_dout, 8'h5A);
    tick;
    chk("st_ack1", bus.ack, 2'b01); chk("st_end_wr", bus.mem_wr, 0);
    bus.req[0] = 1'b0;
    tick;
    setch(1, 1'b1, 1'b0, 3'd4, 32'h50, 32'h44332211);
    tick; tick; tick;
    chk("rw_a2", bus.mem_a, 32'h52); chk("rw_wr2", bus.mem_wr, 1); chk("rw_d2", bus.mem_dout, 8'h33);
    rst = 1'b1;
    bus.req[1] = 1'b0;
    tick;
    rst = 1'b0;
    chk("rw_rst_wr", bus.mem_wr, 0); chk("rw_rst_ack", bus.ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rw_quiet_wr%0d", i), bus.mem_wr, 0);
      chk("rw_quiet_ack", bus.ack, 0);
    end
    xfer(0, 1'b0, 1'b0, 3'd1, 32'h100, 32'h0, cyc, ak);
    chk("rw_after_cyc", cyc, 2); chk("rw_after_ack", ak, 2'b01); chk("rw_after_data", bus.rdata, 32'h11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
